// File: rtl/spi_master.sv
// Single-byte SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with a
// start/busy/done parallel handshake and a 2-flop synchronizer on miso.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  generate
    if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_div
      $error("spi_master: CLK_DIV must be within 4..65535");
    end
  endgenerate

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        miso_p0;
  logic        miso_p1;
  logic        div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // miso synchronizer stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_p0 <= 1'b0;
      miso_p1 <= 1'b0;
    end else begin
      miso_p0 <= miso;
      miso_p1 <= miso_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= din;
            mosi    <= din[7];
            ss      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        default: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            case (state)
              SETUP, SCK_LO: begin
                sck   <= 1'b1;
                state <= SCK_HI;
              end
              SCK_HI: begin
                // Falling sck edge: capture miso, then present the next bit
                sck   <= 1'b0;
                rx_sr <= {rx_sr[6:0], miso_p1};
                if (bit_cnt != 3'd7) begin
                  tx_sr   <= {tx_sr[6:0], 1'b0};
                  mosi    <= tx_sr[6];
                  bit_cnt <= bit_cnt + 3'd1;
                  state   <= SCK_LO;
                end else begin
                  state <= HOLD;
                end
              end
              HOLD: begin
                ss    <= 1'b1;
                mosi  <= 1'b0;
                dout  <= rx_sr;
                done  <= 1'b1;
                state <= GAP;
              end
              GAP: begin
                busy  <= 1'b0;
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and 7), loopback or a
// mode-0 peripheral model on miso, table-driven transfers plus corner sequences.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       miso;
  bit         sel_r = 1'b0;
  bit         mode_r = 1'b0;

  logic [7:0] dout4, dout7;
  logic       busy4, busy7, done4, done7, sck4, sck7, ss4, ss7, mosi4, mosi7;
  logic       start4, start7;

  assign start4 = start && !sel_r;
  assign start7 = start && sel_r;

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .din(din), .dout(dout4), .busy(busy4),
    .done(done4), .sck(sck4), .ss(ss4), .mosi(mosi4), .miso(miso));

  spi_master #(.CLK_DIV(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .din(din), .dout(dout7), .busy(busy7),
    .done(done7), .sck(sck7), .ss(ss7), .mosi(mosi7), .miso(miso));

  always #5 clk = ~clk;

  logic [7:0] dout_v;
  logic       busy_v, done_v, sck_v, ss_v, mosi_v;
  int         div;
  assign dout_v = sel_r ? dout7 : dout4;
  assign busy_v = sel_r ? busy7 : busy4;
  assign done_v = sel_r ? done7 : done4;
  assign sck_v  = sel_r ? sck7  : sck4;
  assign ss_v   = sel_r ? ss7   : ss4;
  assign mosi_v = sel_r ? mosi7 : mosi4;
  assign div    = sel_r ? 7 : 4;

  // Monitor and mode-0 peripheral model (replies 8'h3C)
  int         cyc = 0;
  int         run = 0, rise_cnt = 0, done_cnt = 0, done_off = 0, busy_off = 0;
  int         t0 = 0, ss_rise_cyc = 0, ss_gap = 0, phase_bad = 0;
  logic [7:0] mosi_bits = 8'h00, p_tx = 8'h00, p_rx = 8'h00;
  logic       p_miso = 1'b0, prev_ss = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;

  assign miso = mode_r ? p_miso : mosi_v;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_ss = 1'b1; prev_sck = 1'b0; prev_busy = 1'b0;
      run = 0; rise_cnt = 0; done_cnt = 0;
    end else begin
      run++;
      if (prev_ss && !ss_v) begin
        t0 = cyc; run = 0; rise_cnt = 0; mosi_bits = 8'h00; done_cnt = 0;
        p_tx = 8'h3C; p_rx = 8'h00; p_miso = p_tx[7];
        ss_gap = cyc - ss_rise_cyc;
      end
      if (!prev_ss && ss_v) ss_rise_cyc = cyc;
      if (!prev_sck && sck_v) begin
        if (run != div) phase_bad++;
        run = 0; rise_cnt++;
        mosi_bits = {mosi_bits[6:0], mosi_v};
        p_rx = {p_rx[6:0], mosi_v};
      end
      if (prev_sck && !sck_v) begin
        if (run != div) phase_bad++;
        run = 0;
        p_tx = {p_tx[6:0], 1'b0};
        p_miso = p_tx[7];
      end
      if (sck_v && ss_v) phase_bad++;
      if (done_v) begin
        done_cnt++;
        done_off = cyc - t0;
      end
      if (prev_busy && !busy_v) busy_off = cyc - t0;
      prev_ss = ss_v; prev_sck = sck_v; prev_busy = busy_v;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input bit s, input bit m, input logic [7:0] d);
    sel_r = s; mode_r = m;
    @(negedge clk);
    din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy_v}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_v && n < 30 * div) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy_v}, 32'd0);
  endtask

  task automatic check_xfer(input string name, input logic [7:0] exp_dout,
                            input logic [7:0] exp_mosi, input bit chk_prx);
    repeat (2) @(negedge clk);
    chk({name, "_dout"}, {24'd0, dout_v}, {24'd0, exp_dout});
    chk({name, "_mosi_seq"}, {24'd0, mosi_bits}, {24'd0, exp_mosi});
    chk({name, "_sck_pulses"}, rise_cnt, 8);
    chk({name, "_done_time"}, done_off, 17 * div);
    chk({name, "_busy_fall"}, busy_off, 18 * div);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_phase_err"}, phase_bad, 0);
    chk({name, "_ss_idle"}, {31'd0, ss_v}, 32'd1);
    if (chk_prx) chk({name, "_periph_rx"}, {24'd0, p_rx}, {24'd0, exp_mosi});
  endtask

  typedef struct {
    bit         sel;
    bit         mode;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 1'b0, mode: 1'b0, din: 8'hA5, exp_dout: 8'hA5};
    vecs[1] = '{sel: 1'b0, mode: 1'b1, din: 8'hC3, exp_dout: 8'h3C};
    vecs[2] = '{sel: 1'b1, mode: 1'b1, din: 8'hC3, exp_dout: 8'h3C};
    vecs[3] = '{sel: 1'b1, mode: 1'b0, din: 8'h5A, exp_dout: 8'h5A};
    vecs[4] = '{sel: 1'b0, mode: 1'b0, din: 8'h00, exp_dout: 8'h00};
    vecs[5] = '{sel: 1'b0, mode: 1'b0, din: 8'hFF, exp_dout: 8'hFF};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_r = (s == 1);
      #1;
      chk("rst_sck", {31'd0, sck_v}, 32'd0);
      chk("rst_ss", {31'd0, ss_v}, 32'd1);
      chk("rst_mosi", {31'd0, mosi_v}, 32'd0);
      chk("rst_busy", {31'd0, busy_v}, 32'd0);
      chk("rst_done", {31'd0, done_v}, 32'd0);
      chk("rst_dout", {24'd0, dout_v}, 32'd0);
    end
    sel_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (ss4 !== 1'b1 || sck4 !== 1'b0 || mosi4 !== 1'b0 || done4 !== 1'b0 ||
            ss7 !== 1'b1 || sck7 !== 1'b0 || mosi7 !== 1'b0 || done7 !== 1'b0) bad++;
      end
      chk("idle_100_cycles", bad, 0);
    end

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].sel, vecs[i].mode, vecs[i].din);
      wait_idle("vec_timeout");
      check_xfer($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].din, vecs[i].mode);
    end

    // Second start during an active transfer, with din changed, must be dropped
    launch(1'b0, 1'b0, 8'hA5);
    repeat (19) @(negedge clk);
    din = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ign_timeout");
    check_xfer("ignored_start", 8'hA5, 8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    chk("ignored_no_requeue", done_cnt, 1);
    chk("ignored_ss_high", {31'd0, ss_v}, 32'd1);

    // start held high: two back-to-back transfers
    sel_r = 1'b0; mode_r = 1'b0;
    @(negedge clk);
    din = 8'h5A; start = 1'b1;
    begin
      int n = 0;
      while (!done_v && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_done1_seen", {31'd0, done_v}, 32'd1);
      chk("b2b_dout1", {24'd0, dout_v}, 32'h5A);
      din = 8'h81;
      n = 0;
      while (ss_v && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ss_low2", {31'd0, ss_v}, 32'd0);
      chk("b2b_ss_gap", ss_gap, div + 1);
      start = 1'b0;
    end
    wait_idle("b2b_timeout");
    check_xfer("b2b_second", 8'h81, 8'h81, 1'b0);

    // Asynchronous reset during bit 4
    launch(1'b0, 1'b1, 8'hC3);
    begin
      int n = 0;
      while (rise_cnt < 5 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach_bit4", rise_cnt, 5);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sck", {31'd0, sck_v}, 32'd0);
    chk("mid_rst_ss", {31'd0, ss_v}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_v}, 32'd0);
    chk("mid_rst_done", {31'd0, done_v}, 32'd0);
    chk("mid_rst_mosi", {31'd0, mosi_v}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout_v}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_partial", done_cnt, 0);
    launch(1'b0, 1'b0, 8'h3C);
    wait_idle("post_rst_timeout");
    check_xfer("post_rst", 8'h3C, 8'h3C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
